// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder sequencer driving an external 4-bit carry-lookahead slice.
// Optional signed-overflow output enabled by defining CLA_SER_OVF_EN.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef CLA_SER_OVF_EN
  output logic             out_ovf,
`endif
  output logic [3:0]       slc_a,
  output logic [3:0]       slc_b,
  output logic             slc_cin,
  input  logic [3:0]       slc_sum,
  input  logic             slc_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-5:0] sum_sh_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_sum_r;
  logic             out_cout_r;
  logic [WIDTH-1:0] sum_next_s;
`ifdef CLA_SER_OVF_EN
  logic             out_ovf_r;
  assign out_ovf = out_ovf_r;
`endif

  // Operands shift right one nibble per RUN cycle, so the active nibble is always [3:0];
  // sum nibbles shift in from the top and land in place after NIB cycles.
  assign sum_next_s = {slc_sum, sum_sh_r};

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_cout  = out_cout_r;

  // Slice drive: registered operand nibbles and chained carry, quiet outside RUN.
  always_comb begin
    slc_a   = 4'h0;
    slc_b   = 4'h0;
    slc_cin = 1'b0;
    if (state_r == RUN) begin
      slc_a   = a_sh_r[3:0];
      slc_b   = b_sh_r[3:0];
      slc_cin = carry_r;
    end else begin
      slc_a   = 4'h0;
      slc_b   = 4'h0;
      slc_cin = 1'b0;
    end
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      carry_r     <= 1'b0;
      a_sh_r      <= {WIDTH{1'b0}};
      b_sh_r      <= {WIDTH{1'b0}};
      sum_sh_r    <= {(WIDTH-4){1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_sum_r   <= {WIDTH{1'b0}};
      out_cout_r  <= 1'b0;
`ifdef CLA_SER_OVF_EN
      out_ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r     <= in_a;
            b_sh_r     <= in_b;
            carry_r    <= in_cin;
            cnt_r      <= CNT_ZERO;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          a_sh_r   <= {4'h0, a_sh_r[WIDTH-1:4]};
          b_sh_r   <= {4'h0, b_sh_r[WIDTH-1:4]};
          sum_sh_r <= sum_next_s[WIDTH-1:4];
          carry_r  <= slc_cout;
          if (cnt_r == CNT_LAST) begin
            out_sum_r   <= sum_next_s;
            out_cout_r  <= slc_cout;
`ifdef CLA_SER_OVF_EN
            // Carry into the MSB recovered from the slice's top sum bit.
            out_ovf_r   <= slc_cout ^ (slc_sum[3] ^ a_sh_r[3] ^ b_sh_r[3]);
`endif
            cnt_r       <= CNT_ZERO;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= CNT_ZERO;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Scoreboard bench for cla_nibble_serial_adder (WIDTH=16) with an ideal 4-bit slice model.
module tb_cla_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [3:0]       slc_a;
  logic [3:0]       slc_b;
  logic             slc_cin;
  logic [3:0]       slc_sum;
  logic             slc_cout;
`ifdef CLA_SER_OVF_EN
  logic             out_ovf;
`endif

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   cyc       = 0;
  logic prev_ov   = 1'b0;
  logic b2b       = 1'b0;
  logic have_prev = 1'b0;
  int   prev_acc  = 0;

  cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
`ifdef CLA_SER_OVF_EN
    .out_ovf(out_ovf),
`endif
    .slc_a(slc_a), .slc_b(slc_b), .slc_cin(slc_cin),
    .slc_sum(slc_sum), .slc_cout(slc_cout)
  );

  // Ideal 4-bit slice
  assign {slc_cout, slc_sum} = {1'b0, slc_a} + {1'b0, slc_b} + {4'h0, slc_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: push expectations on accept, compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
        logic [WIDTH:0] full;
        full = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
        e.sum     = full[WIDTH-1:0];
        e.cout    = full[WIDTH];
        e.ovf     = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (full[WIDTH-1] != in_a[WIDTH-1]);
        e.acc_cyc = cyc;
        sb.push_back(e);
        if (b2b) begin
          if (have_prev) chk("b2b_gap", 32'(cyc - prev_acc), 32'(NIB + 2));
          prev_acc  = cyc;
          have_prev = 1'b1;
        end
      end
      if (out_valid && !prev_ov && sb.size() > 0)
        chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(NIB + 1));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_sum", 32'(out_sum), 32'(e.sum));
          chk("out_cout", 32'(out_cout), 32'(e.cout));
`ifdef CLA_SER_OVF_EN
          chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
`endif
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      logic acc;
      acc = in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 50; i++) begin
      if (out_valid) return;
      tick();
    end
    chk("out_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    logic [3:0] exp_a [4];
    logic       exp_c [4];
    exp_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    exp_c = '{1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_cin = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_sum", 32'(out_sum), 32'(0));
    chk("rst_out_cout", 32'(out_cout), 32'(0));
    chk("rst_slc_a", 32'(slc_a), 32'(0));
    rst_n = 1'b1;
    tick();

    send(16'hFFFF, 16'h0001, 1'b0);
    wait_out();
    tick();
    send(16'h7FFF, 16'h0001, 1'b0);
    wait_out();
    tick();

    // Slice drive sequence
    send(16'h1234, 16'h4321, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("slc_a_seq", 32'(slc_a), 32'(exp_a[i]));
      chk("slc_cin_seq", 32'(slc_cin), 32'(exp_c[i]));
      tick();
    end
    chk("done_slc_a", 32'(slc_a), 32'(0));
    chk("done_out_valid", 32'(out_valid), 32'(1));
    chk("sum_1234", 32'(out_sum), 32'(16'h5556));
    tick();

    // Backpressure in DONE; new operands must be ignored
    out_ready = 1'b0;
    send(16'hABCD, 16'h1234, 1'b0);
    wait_out();
    in_a = 16'h5555; in_b = 16'h5555; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'(1));
      chk("bp_out_sum", 32'(out_sum), 32'(16'hBE01));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 32'(in_ready), 32'(1));
    chk("bp_release_out_valid", 32'(out_valid), 32'(0));

    // Reset in RUN at cnt==2
    send(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    chk("mid_rst_out_sum", 32'(out_sum), 32'(0));
    chk("mid_rst_out_cout", 32'(out_cout), 32'(0));
    send(16'h00FF, 16'h0001, 1'b0);
    wait_out();
    chk("after_rst_sum", 32'(out_sum), 32'(16'h0100));
    tick();

    // Back-to-back random operations
    b2b = 1'b1;
    have_prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    b2b = 1'b0;
    chk("drain", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
